e_mdu: RTL and testbench

- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency.
- Executes mthi/mtlo and serves mfhi/mflo reads; the read value feeds the E-stage HILOResult input of the EX/MEM pipeline register.
- Exports start/busy so the hazard unit can stall later HI/LO-dependent instructions in D.

---
 rtl/e_mdu.sv | 185 ++++++++++++++++++
 tb/tb_e_mdu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
//
// Owns the architectural HI/LO registers. It executes mult/multu/div/divu
// with a fixed busy latency, executes mthi/mtlo in a single cycle, and serves
// mfhi/mflo reads combinationally.
//
// The result of a started operation is computed in the start cycle and
// parked in pending registers. A countdown then models the iterative unit's
// latency. HI/LO are committed at the edge where the countdown reaches zero.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   mdu_op       in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                         5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   start        in   1   qualifies ops 1-4 (one-cycle pulse)
//   rs_val       in  32   multiplicand / dividend / mthi-mtlo source
//   rt_val       in  32   multiplier / divisor
//   busy         out  1   operation in progress
//   hi           out 32   architectural HI
//   lo           out 32   architectural LO
//   hilo_result  out 32   HI for mfhi, LO for mflo, else 0
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hilo_result
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // State
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;   // low for divide-by-zero: commit nothing
  logic [CNT_W-1:0] count_q, count_d;

  // -------------------------------------------------------------------------
  // Arithmetic datapath
  // -------------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        rt_nz;
  logic [31:0] divisor;
  logic [31:0] uq, ur;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [31:0] mq, mr;
  logic [31:0] sq, sr;

  always_comb begin
    // The low 64 bits of a product of sign-extended operands equal the
    // signed 32x32 product, so one unsigned multiplier shape serves both.
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Substitute 1 for a zero divisor so the datapath never sees X; the
    // result is discarded anyway through pend_we.
    rt_nz   = (rt_val != 32'd0);
    divisor = rt_nz ? rt_val : 32'd1;

    uq = rs_val / divisor;
    ur = rs_val % divisor;

    // Signed divide on magnitudes. The magnitude of 0x80000000 is 2^31,
    // which fits unsigned, so 0x80000000 / -1 naturally yields 0x80000000
    // with remainder 0 and needs no special case.
    rs_neg = rs_val[31];
    rt_neg = divisor[31];
    rs_mag = rs_neg ? (32'd0 - rs_val)  : rs_val;
    rt_mag = rt_neg ? (32'd0 - divisor) : divisor;
    mq     = rs_mag / rt_mag;
    mr     = rs_mag % rt_mag;
    sq     = (rs_neg ^ rt_neg) ? (32'd0 - mq) : mq;
    sr     = rs_neg ? (32'd0 - mr) : mr;   // remainder follows the dividend
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    count_d   = count_q;

    if (count_q != '0) begin
      // Busy: everything else is ignored until the countdown expires.
      count_d = count_q - CNT_W'(1);
      if (count_q == CNT_W'(1) && pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      if (start) begin
        unique case (mdu_op)
          OP_MULT: begin
            {pend_hi_d, pend_lo_d} = prod_s;
            pend_we_d = 1'b1;
            count_d   = CNT_W'(MULT_CYCLES);
          end
          OP_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod_u;
            pend_we_d = 1'b1;
            count_d   = CNT_W'(MULT_CYCLES);
          end
          OP_DIV: begin
            pend_hi_d = sr;
            pend_lo_d = sq;
            pend_we_d = rt_nz;
            count_d   = CNT_W'(DIV_CYCLES);
          end
          OP_DIVU: begin
            pend_hi_d = ur;
            pend_lo_d = uq;
            pend_we_d = rt_nz;
            count_d   = CNT_W'(DIV_CYCLES);
          end
          default: ;
        endcase
      end

      // mthi/mtlo do not depend on start.
      if (mdu_op == OP_MTHI) hi_d = rs_val;
      if (mdu_op == OP_MTLO) lo_d = rs_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      count_q   <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      count_q   <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy = (count_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    hilo_result = 32'd0;
    if (mdu_op == OP_MFHI) hilo_result = hi_q;
    if (mdu_op == OP_MFLO) hilo_result = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
//
// Each started multiply/divide pushes its expected HI/LO and busy length to
// a scoreboard queue. A negedge monitor pops the queue when busy falls.
// Direct checks cover reset, mthi/mtlo, hilo_result and ignored requests.
// ---------------------------------------------------------------------------
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_result;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .mdu_op      (mdu_op),
    .start       (start),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .hilo_result (hilo_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [31:0] old_hi   = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model in 64-bit integer arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output int cyc);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    rhi = model_hi;
    rlo = model_lo;
    cyc = 10;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); {rhi, rlo} = p; cyc = 5; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {rhi, rlo} = p; cyc = 5; end
      4'd3: if (b != 0) begin
              sq = sa / sb; sr = sa % sb;
              rlo = sq[31:0]; rhi = sr[31:0];
            end
      4'd4: if (b != 0) begin rlo = a / b; rhi = a % b; end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs starting at posedge+1, return at next posedge+1.
  task automatic issue(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op; start = st; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    mdu_op = 4'd0; start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model_op(op, a, b, e.hi, e.lo, e.cycles);
    old_hi   = model_hi;
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);
    $display("[TB] start op=%0d rs=0x%08h rt=0x%08h exp hi=0x%08h lo=0x%08h", op, a, b, e.hi, e.lo);
    issue(op, 1'b1, a, b);
  endtask

  task automatic wait_idle(input string tag);
    int ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy && sb_q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_read(input string tag, input logic [3:0] op, input logic [31:0] exp);
    mdu_op = op;
    #1;
    check(tag, hilo_result, exp);
    mdu_op = 4'd0;
    #1;
  endtask

  // Scoreboard monitor: a falling busy marks a completed operation.
  int   busy_len  = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("busy_len", 64'(busy_len), 64'(mon_e.cycles));
          check("hi", hi, mon_e.hi);
          check("lo", lo, mon_e.lo);
          $display("[TB] done busy=%0d hi=0x%08h lo=0x%08h", busy_len, hi, lo);
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Signed multiply
    start_op(4'd1, 32'hFFFFFFFD, 32'd4);
    check("mult_busy", busy, 1'b1);
    wait_idle("mult");
    check_read("mfhi_mult", 4'd7, 32'hFFFFFFFF);
    check_read("mflo_mult", 4'd8, 32'hFFFFFFF4);
    check_read("op9_zero", 4'd9, 32'd0);

    // Unsigned multiply
    start_op(4'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu");
    check_read("mfhi_multu", 4'd7, 32'h00000001);
    check_read("mflo_multu", 4'd8, 32'hFFFFFFFE);

    // Signed divide, overflow corner, unsigned divide
    start_op(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");
    start_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");
    start_op(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_neg_divisor");
    start_op(4'd4, 32'd100, 32'd7);
    wait_idle("divu");

    // mthi/mtlo then divide by zero
    issue(4'd5, 1'b0, 32'h11111111, 32'd0);
    model_hi = 32'h11111111;
    check("mthi", hi, 32'h11111111);
    check("mthi_nobusy", busy, 1'b0);
    issue(4'd6, 1'b0, 32'h22222222, 32'd0);
    model_lo = 32'h22222222;
    check("mtlo", lo, 32'h22222222);
    start_op(4'd4, 32'h12345678, 32'd0);
    wait_idle("divu_zero");
    check("div0_hi", hi, 32'h11111111);
    check("div0_lo", lo, 32'h22222222);

    // Requests during busy are ignored
    start_op(4'd3, 32'h7FFFFFFF, 32'h10);
    issue(4'd0, 1'b0, 32'd0, 32'd0);
    check_read("mfhi_busy_old", 4'd7, old_hi);
    issue(4'd5, 1'b0, 32'hAAAAAAAA, 32'd0);
    issue(4'd1, 1'b1, 32'd5, 32'd6);
    check("busy_hold", busy, 1'b1);
    wait_idle("ignored");

    // start with non-arithmetic op is ignored
    issue(4'd0, 1'b1, 32'd3, 32'd3);
    check("start_op0", busy, 1'b0);
    issue(4'd9, 1'b1, 32'd3, 32'd3);
    check("start_op9", busy, 1'b0);
    check("start_op9_hi", hi, model_hi);

    // Reset mid-operation
    start_op(4'd1, 32'd7, 32'd9);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    sb_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("postrst_hi", hi, 32'd0);
    check("postrst_lo", lo, 32'd0);
    check("postrst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
